// File: rtl/uart_intpt_ctrl.sv
// UART interrupt controller: prioritises line status, RX data, character timeout
// and THRE sources into a registered interrupt line and a 16550-style IIR code.
module uart_intpt_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1),
  parameter int OVS        = 16,
  parameter int TO_CHARS   = 4,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             thre,
  input  logic             etbei,
  input  logic             pe,
  input  logic             fe,
  input  logic             bi,
  input  logic             oe,
  input  logic             elsi,
  input  logic             dr,
  input  logic             erbi,
  input  logic             fifo_en,
  input  logic [1:0]       rx_trig,
  input  logic [LVL_W-1:0] rx_level,
  input  logic             rx_push,
  input  logic             rx_pop,
  input  logic             thr_wr,
  input  logic             iir_rd,
  input  logic             baud_tick,
  input  logic [3:0]       frame_bits,
  output logic             uart_intpt,
  output logic [3:0]       iir
);

  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_CTI  = 4'b1100;
  localparam logic [3:0] IIR_THRI = 4'b0010;
  localparam logic [3:0] IIR_NONE = 4'b0001;

  logic             thre_pend_r;
  logic             thre_en_d_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       iir_r;
  logic             intpt_r;

  logic [LVL_W-1:0] trig_val_s;
  logic [CNT_W-1:0] thresh_s;
  logic             thre_rise_s;
  logic             cnt_clr_s;
  logic             rls_s;
  logic             rda_s;
  logic             cti_s;
  logic [3:0]       iir_nxt_s;

  // Decode the RX FIFO trigger level from the FCR selection.
  always_comb begin
    trig_val_s = LVL_W'(1);
    case (rx_trig)
      2'd0:    trig_val_s = LVL_W'(1);
      2'd1:    trig_val_s = LVL_W'(FIFO_DEPTH / 4);
      2'd2:    trig_val_s = LVL_W'(FIFO_DEPTH / 2);
      2'd3:    trig_val_s = LVL_W'(FIFO_DEPTH - 2);
      default: trig_val_s = LVL_W'(1);
    endcase
  end

  // Source conditions and timeout threshold for the current frame length.
  always_comb begin
    thresh_s    = CNT_W'(TO_CHARS * OVS) * {{(CNT_W-4){1'b0}}, frame_bits};
    thre_rise_s = thre & etbei & ~thre_en_d_r;
    cnt_clr_s   = ~fifo_en | (rx_level == LVL_W'(0)) | rx_push | rx_pop;
    rls_s       = (pe | fe | bi | oe) & elsi;
    if (fifo_en) begin
      rda_s = erbi & (rx_level >= trig_val_s);
    end else begin
      rda_s = erbi & dr;
    end
    cti_s = erbi & fifo_en & (cnt_r == thresh_s);
  end

  // Fixed-priority encoder; only the highest active source is reported.
  always_comb begin
    iir_nxt_s = IIR_NONE;
    if (rls_s) begin
      iir_nxt_s = IIR_RLS;
    end else if (rda_s) begin
      iir_nxt_s = IIR_RDA;
    end else if (cti_s) begin
      iir_nxt_s = IIR_CTI;
    end else if (thre_pend_r) begin
      iir_nxt_s = IIR_THRI;
    end else begin
      iir_nxt_s = IIR_NONE;
    end
  end

  // Sticky THRE flag: set wins over an IIR read, but THR write or disable override set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thre_pend_r <= 1'b0;
      thre_en_d_r <= 1'b0;
    end else begin
      thre_en_d_r <= thre & etbei;
      if (!etbei || thr_wr) begin
        thre_pend_r <= 1'b0;
      end else if (thre_rise_s) begin
        thre_pend_r <= 1'b1;
      end else if (iir_rd && (iir_r == IIR_THRI)) begin
        thre_pend_r <= 1'b0;
      end else begin
        thre_pend_r <= thre_pend_r;
      end
    end
  end

  // Character-timeout counter; saturates at (or above) the threshold, never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (baud_tick && (cnt_r < thresh_s)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered interrupt outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iir_r   <= IIR_NONE;
      intpt_r <= 1'b0;
    end else begin
      iir_r   <= iir_nxt_s;
      intpt_r <= (iir_nxt_s != IIR_NONE);
    end
  end

  assign iir        = iir_r;
  assign uart_intpt = intpt_r;

endmodule

// File: tb/tb_uart_intpt_ctrl.sv
// Scoreboard bench for uart_intpt_ctrl: directed stimulus pushes expected IIR codes,
// a negedge monitor pops and compares against the registered outputs.
module tb_uart_intpt_ctrl;

  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n, thre, etbei, pe, fe, bi, oe, elsi, dr, erbi, fifo_en;
  logic [1:0]       rx_trig;
  logic [LVL_W-1:0] rx_level;
  logic             rx_push, rx_pop, thr_wr, iir_rd, baud_tick;
  logic [3:0]       frame_bits;
  logic             uart_intpt;
  logic [3:0]       iir;

  typedef struct {
    logic [3:0] e_iir;
    logic       e_int;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  uart_intpt_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .thre(thre), .etbei(etbei),
    .pe(pe), .fe(fe), .bi(bi), .oe(oe), .elsi(elsi), .dr(dr), .erbi(erbi),
    .fifo_en(fifo_en), .rx_trig(rx_trig), .rx_level(rx_level),
    .rx_push(rx_push), .rx_pop(rx_pop), .thr_wr(thr_wr), .iir_rd(iir_rd),
    .baud_tick(baud_tick), .frame_bits(frame_bits),
    .uart_intpt(uart_intpt), .iir(iir)
  );

  always #5 clk = ~clk;

  // One clock edge; the outputs after this edge must equal e_iir.
  task automatic tick(input logic [3:0] e_iir, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    e.e_iir = e_iir;
    e.e_int = (e_iir != 4'b0001);
    e.name  = nm;
    sb.push_back(e);
  endtask

  task automatic ticks(input int n, input logic [3:0] e_iir, input string nm);
    for (int i = 0; i < n; i++) tick(e_iir, nm);
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (iir !== e.e_iir || uart_intpt !== e.e_int) begin
        failures++;
        $display("FAIL %s: got iir=%b intpt=%b, want iir=%b intpt=%b at %0t",
                 e.name, iir, uart_intpt, e.e_iir, e.e_int, $time);
      end
    end
  end

  initial begin
    rst_n = 1'b0; thre = 1'b1; etbei = 1'b1;
    pe = 1'b0; fe = 1'b0; bi = 1'b0; oe = 1'b0; elsi = 1'b0;
    dr = 1'b0; erbi = 1'b0; fifo_en = 1'b0; rx_trig = 2'd0; rx_level = '0;
    rx_push = 1'b0; rx_pop = 1'b0; thr_wr = 1'b0; iir_rd = 1'b0;
    baud_tick = 1'b0; frame_bits = 4'd10;

    // Reset with THRE enabled, then release
    ticks(2, 4'b0001, "reset");
    rst_n = 1'b1;
    tick(4'b0001, "release_edge");
    tick(4'b0010, "thre_after_release");
    iir_rd = 1'b1; tick(4'b0010, "iir_rd_edge"); iir_rd = 1'b0;
    ticks(2, 4'b0001, "thre_cleared_by_read");

    // etbei 0->1 with thre held high
    etbei = 1'b0; tick(4'b0001, "etbei_low");
    etbei = 1'b1; tick(4'b0001, "etbei_rise_edge");
    tick(4'b0010, "thre_from_etbei");

    // Line status outranks THRE; IIR read there keeps THRE pending
    fe = 1'b1; elsi = 1'b1; tick(4'b0110, "rls_over_thre");
    iir_rd = 1'b1; tick(4'b0110, "rls_read"); iir_rd = 1'b0;
    fe = 1'b0; tick(4'b0010, "thre_resurfaces");
    thr_wr = 1'b1; tick(4'b0010, "thr_wr_edge"); thr_wr = 1'b0;
    tick(4'b0001, "thre_cleared_by_wr");
    etbei = 1'b0; tick(4'b0001, "etbei_off");

    // Trigger levels
    fifo_en = 1'b1; erbi = 1'b1; rx_trig = 2'd2;
    rx_level = LVL_W'(7);  tick(4'b0001, "trig8_lvl7");
    rx_level = LVL_W'(8);  tick(4'b0100, "trig8_lvl8");
    rx_trig = 2'd3;        tick(4'b0001, "trig14_lvl8");
    rx_level = LVL_W'(14); tick(4'b0100, "trig14_lvl14");
    rx_trig = 2'd1; rx_level = LVL_W'(3); tick(4'b0001, "trig4_lvl3");
    rx_level = LVL_W'(4);  tick(4'b0100, "trig4_lvl4");
    pe = 1'b1;             tick(4'b0110, "rls_over_rda");
    pe = 1'b0; rx_trig = 2'd0; rx_level = LVL_W'(1); tick(4'b0100, "trig1_lvl1");

    // Character timeout: 640 ticks at 10 bits per frame
    rx_trig = 2'd3; rx_push = 1'b1; tick(4'b0001, "to_clear"); rx_push = 1'b0;
    baud_tick = 1'b1;
    ticks(640, 4'b0001, "to_counting");
    tick(4'b1100, "to_fire");
    ticks(5, 4'b1100, "to_saturated");
    rx_pop = 1'b1; tick(4'b1100, "to_pop_edge"); rx_pop = 1'b0;
    tick(4'b0001, "to_cleared_by_pop");

    // Pop on tick 639 restarts the count
    rx_push = 1'b1; tick(4'b0001, "to2_clear"); rx_push = 1'b0;
    ticks(638, 4'b0001, "to2_counting");
    rx_pop = 1'b1; tick(4'b0001, "to2_pop639"); rx_pop = 1'b0;
    ticks(50, 4'b0001, "to2_no_fire");

    // Shrinking the frame below the running count holds it without firing
    rx_push = 1'b1; tick(4'b0001, "to3_clear"); rx_push = 1'b0;
    ticks(500, 4'b0001, "to3_counting");
    frame_bits = 4'd7;
    ticks(100, 4'b0001, "to3_over_thresh");
    rx_pop = 1'b1; tick(4'b0001, "to3_pop"); rx_pop = 1'b0;
    ticks(448, 4'b0001, "to7_counting");
    tick(4'b1100, "to7_fire");

    // Reset mid-operation drops the interrupt
    rst_n = 1'b0; tick(4'b0001, "reset_mid"); rst_n = 1'b1;
    frame_bits = 4'd10;
    ticks(3, 4'b0001, "after_reset_mid");

    // Non-FIFO mode: dr drives RDA, timeout never shown
    fifo_en = 1'b0; dr = 1'b1; rx_level = LVL_W'(5);
    ticks(1000, 4'b0100, "nonfifo_rda");
    dr = 1'b0;
    ticks(20, 4'b0001, "nonfifo_idle");
    baud_tick = 1'b0;
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, stimulus_done=%0d want 1", stim_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
